// File: rtl/sat_fifo_pkg.sv
// Shared types and default sizing for the FIFO arbitration tree.
package sat_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    localparam int DATA_WIDTH = 36;
    localparam int NUM_FIFOS  = 4;

endpackage

// File: rtl/FIFO_Buffer.sv
// Synchronous FIFO with a registered read port: a word requested with rden_i
// appears on data_o after the next rising edge.
module FIFO_Buffer #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wren_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rden_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  do_wr;
    logic                  do_rd;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_wr   = wren_i && !full_o;
    assign do_rd   = rden_i && !empty_o;
    assign data_o  = data_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                data_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester strictly after 'last',
// wrapping modulo N. Kept standalone so wider arbitration trees can reuse it.
module rr_pick #(
    parameter int N   = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = int'(last) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!grant_vld && req[IW'(j)]) begin
                grant_idx = IW'(j);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains NUM_FIFOS upstream FIFOs round-robin into one registered valid/ready
// output, issuing at most one read per two cycles.
module fifo_rr_arbiter
    import sat_fifo_pkg::*;
#(
    parameter int NUM_FIFOS  = sat_fifo_pkg::NUM_FIFOS,
    parameter int DATA_WIDTH = sat_fifo_pkg::DATA_WIDTH,
    localparam int IDX_W     = $clog2(NUM_FIFOS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_FIFOS-1:0]            fifo_empty_i,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data_i,
    output logic [NUM_FIFOS-1:0]            fifo_rden_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic [IDX_W-1:0]                src_o,
    output logic                            valid_o,
    input  logic                            ready_i
);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      last_q;
    logic [IDX_W-1:0]      last_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [IDX_W-1:0]      src_q;
    logic                  valid_q;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  pick_en;
    logic                  issue_d;
    logic [NUM_FIFOS-1:0]  rden_d;

    rr_pick #(
        .N(NUM_FIFOS)
    ) u_pick (
        .req       (~fifo_empty_i),
        .last      (last_q),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Empties only matter while idle or when the held word is leaving.
    assign pick_en = reset && ((state_q == IDLE) || (state_q == HOLD && ready_i));
    assign issue_d = pick_en && pick_vld;
    assign last_d  = issue_d ? pick_idx : last_q;

    always_comb begin
        rden_d = '0;
        if (issue_d) begin
            rden_d[pick_idx] = 1'b1;
        end
    end

    assign fifo_rden_o = rden_d;
    assign data_o      = data_q;
    assign src_o       = src_q;
    assign valid_o     = valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_FIFOS - 1);
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            last_q <= last_d;
            case (state_q)
                IDLE: begin
                    if (issue_d) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // last_q still names the FIFO read on the previous edge.
                    data_q  <= fifo_data_i[last_q*DATA_WIDTH +: DATA_WIDTH];
                    src_q   <= last_q;
                    valid_q <= 1'b1;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= issue_d ? WAIT : IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench: four real FIFO_Buffer instances feed the arbiter; a queue-based model
// predicts reads, output timing and the delivered word stream.
module tb_fifo_rr_arbiter;

    localparam int N = 4;
    localparam int W = 36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           fifo_rst_n;
    logic           ready_i;
    logic [N-1:0]   wren;
    logic [W-1:0]   wdata [N];
    logic [N-1:0]   fifo_empty;
    logic [N-1:0]   fifo_full;
    logic [N-1:0]   fifo_rden;
    logic [N*W-1:0] fifo_data;
    logic [W-1:0]   data_o;
    logic [1:0]     src_o;
    logic           valid_o;

    for (genvar g = 0; g < N; g++) begin : g_fifo
        FIFO_Buffer #(.DATA_WIDTH(W), .DEPTH(32)) u_fifo (
            .clk     (clk),
            .reset   (fifo_rst_n),
            .wren_i  (wren[g]),
            .data_i  (wdata[g]),
            .rden_i  (fifo_rden[g]),
            .data_o  (fifo_data[g*W +: W]),
            .empty_o (fifo_empty[g]),
            .full_o  (fifo_full[g])
        );
    end

    fifo_rr_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rden_o  (fifo_rden),
        .data_o       (data_o),
        .src_o        (src_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    typedef struct {
        int           src;
        logic [W-1:0] data;
        int           g;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mq[N][$];
    int           acc_src[$];
    int           acc_ec[$];
    int           last_m = N - 1;
    int           ec = 0;
    int           errors = 0;
    int           checks = 0;
    int           n_written = 0;
    bit           armed = 0;

    function automatic int rr_model(int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (mq[j].size() > 0) return j;
        end
        return -1;
    endfunction

    function automatic bit all_drained();
        bit e;
        e = (exp_q.size() == 0);
        for (int n = 0; n < N; n++) if (mq[n].size() != 0) e = 0;
        return e;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input logic [N-1:0] wr, input logic rdy, input logic rst_n);
        logic [N-1:0] erden;
        logic         evld;
        logic [63:0]  r;
        logic [W-1:0] wd [N];
        int           pick;
        @(negedge clk);
        reset   = rst_n;
        ready_i = rdy;
        wren    = wr;
        for (int n = 0; n < N; n++) begin
            r        = {$urandom, $urandom};
            wd[n]    = r[W-1:0];
            wdata[n] = wd[n];
        end
        #1;
        evld = (exp_q.size() > 0) && (ec >= exp_q[0].g + 1);
        pick = -1;
        if (rst_n && (exp_q.size() == 0 || (evld && rdy))) pick = rr_model(last_m);
        erden = '0;
        if (pick >= 0) erden[pick] = 1'b1;
        if (armed) begin
            checks++;
            if (fifo_rden !== erden) begin
                errors++;
                $display("FAIL rden edge=%0d: got %b required %b", ec, fifo_rden, erden);
            end
            checks++;
            if (valid_o !== evld) begin
                errors++;
                $display("FAIL valid edge=%0d: got %b required %b", ec, valid_o, evld);
            end
            checks++;
            if ((fifo_rden & fifo_empty) !== '0) begin
                errors++;
                $display("FAIL rden_on_empty edge=%0d: rden %b empty %b required no overlap", ec, fifo_rden, fifo_empty);
            end
            if (evld) begin
                checks++;
                if (data_o !== exp_q[0].data) begin
                    errors++;
                    $display("FAIL data edge=%0d: got %h required %h", ec, data_o, exp_q[0].data);
                end
                checks++;
                if (int'(src_o) != exp_q[0].src) begin
                    errors++;
                    $display("FAIL src edge=%0d: got %0d required %0d", ec, src_o, exp_q[0].src);
                end
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            last_m = N - 1;
            armed  = 1;
        end else begin
            if (evld && rdy) begin
                acc_src.push_back(exp_q[0].src);
                acc_ec.push_back(ec + 1);
                void'(exp_q.pop_front());
            end
            if (pick >= 0) begin
                exp_q.push_back('{src: pick, data: mq[pick].pop_front(), g: ec + 1});
                last_m = pick;
            end
        end
        for (int n = 0; n < N; n++) begin
            if (wr[n]) begin
                mq[n].push_back(wd[n]);
                n_written++;
            end
        end
        @(posedge clk);
        ec++;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (!all_drained() && c < budget) begin
            step('0, 1'b1, 1'b1);
            c++;
        end
        step('0, 1'b1, 1'b1);
        checks++;
        if (!all_drained()) begin
            errors++;
            $display("FAIL drain_timeout: %0d words still pending, required 0", exp_q.size());
        end
    endtask

    task automatic check_seq(input string name, input int want[$]);
        checks++;
        if (acc_src != want) begin
            errors++;
            $display("FAIL %s: got src sequence %p required %p", name, acc_src, want);
        end
    endtask

    task automatic fresh_reset();
        step('0, 1'b1, 1'b0);
        acc_src.delete();
        acc_ec.delete();
    endtask

    task automatic test_reset();
        acc_src.delete();
        step(4'b0011, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        #2;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_o); end
        checks++;
        if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", data_o); end
        checks++;
        if (src_o !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d required 0", src_o); end
        checks++;
        if (fifo_rden !== '0) begin errors++; $display("FAIL reset_rden: got %b required 0", fifo_rden); end
        drain(50);
        check_seq("reset_first_priority", '{0, 1});
    endtask

    task automatic test_single_fifo();
        fresh_reset();
        repeat (3) step(4'b0100, 1'b1, 1'b1);
        drain(50);
        check_seq("single_fifo_src", '{2, 2, 2});
        checks++;
        if (acc_ec.size() != 3 || acc_ec[1] - acc_ec[0] != 2 || acc_ec[2] - acc_ec[1] != 2) begin
            errors++;
            $display("FAIL single_fifo_rate: accept edges %p required spacing 2", acc_ec);
        end
    endtask

    task automatic test_all_fifos();
        fresh_reset();
        repeat (2) step(4'b1111, 1'b1, 1'b1);
        drain(60);
        check_seq("all_fifos_rr", '{0, 1, 2, 3, 0, 1, 2, 3});
    endtask

    task automatic test_backpressure();
        fresh_reset();
        step(4'b1010, 1'b0, 1'b1);
        repeat (12) step('0, 1'b0, 1'b1);
        drain(50);
        check_seq("backpressure_order", '{1, 3});
    endtask

    task automatic test_late_arrival();
        fresh_reset();
        step(4'b1000, 1'b1, 1'b1);
        step(4'b1010, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b1);
        drain(60);
        check_seq("late_arrival_rr", '{3, 1, 3, 3, 3});
    endtask

    task automatic test_reset_in_wait();
        fresh_reset();
        step(4'b0100, 1'b1, 1'b1);
        step(4'b1001, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0);
        #2;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL wait_reset_valid: got %b required 0", valid_o); end
        acc_src.delete();
        drain(50);
        check_seq("wait_reset_priority", '{0, 3});
    endtask

    task automatic test_idle();
        fresh_reset();
        repeat (20) step('0, 1'b1, 1'b1);
        check_seq("idle_no_output", '{});
    endtask

    task automatic test_random();
        logic [N-1:0] wr;
        int           base;
        fresh_reset();
        base = n_written;
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < N; n++) wr[n] = (mq[n].size() < 28) && ($urandom_range(0, 3) == 0);
            step(wr, $urandom_range(0, 3) != 0, 1'b1);
            checks++;
            if (fifo_full !== '0) begin
                errors++;
                $display("FAIL random_full: got %b required 0", fifo_full);
            end
        end
        drain(400);
        checks++;
        if (acc_src.size() != n_written - base) begin
            errors++;
            $display("FAIL random_count: delivered %0d required %0d", acc_src.size(), n_written - base);
        end
    endtask

    initial begin
        reset      = 1'b0;
        fifo_rst_n = 1'b0;
        ready_i    = 1'b0;
        wren       = '0;
        for (int n = 0; n < N; n++) wdata[n] = '0;
        repeat (2) step('0, 1'b0, 1'b0);
        #1 fifo_rst_n = 1'b1;
        test_reset();
        test_single_fifo();
        test_all_fifos();
        test_backpressure();
        test_late_arrival();
        test_reset_in_wait();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
